// File: rtl/dbg_ctrl_pkg.sv
// Shared definitions for the debug run-control block.
// Contents: run-control FSM state encoding and bus width constants.
package dbg_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_HALTED    = 2'd2,
        ST_RESET     = 2'd3
    } state_e;

endpackage

// File: rtl/dbg_bus_arb.sv
// Memory port arbiter between the core master and the debug master.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_state             run-control FSM state
//   i_dbg_*             debug access request (held stable until ack)
//   o_dbg_rdata/ack     registered read data and one-cycle completion pulse
//   i_core_*            core bus request
//   i_m_rdata           bus read data (combinational)
//   o_m_*               master port to the bus
//   o_starve_hold       stall the core so a starved debug access can go
module dbg_bus_arb
    import dbg_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_e            i_state,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_ack,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_m_req,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    output logic              o_starve_hold
);

    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_starve_cnt;

    logic w_pending;
    logic w_starved;
    logic w_gnt;
    logic w_core_pass;

    // The request is still held high during the ack cycle; it must not count
    // as a new access, otherwise the same operation would be issued twice.
    assign w_pending = i_dbg_req & ~r_ack;
    assign w_starved = (r_starve_cnt >= 8'(STARVE_MAX));

    // Grant decision per run-control state.
    always_comb begin
        w_gnt       = 1'b0;
        w_core_pass = 1'b0;
        case (i_state)
            ST_RUN: begin
                w_core_pass = 1'b1;
                w_gnt       = w_pending & (~i_core_req | w_starved);
            end
            ST_HALT_WAIT: begin
                w_core_pass = 1'b1;
            end
            ST_HALTED: begin
                w_gnt = w_pending;
            end
            ST_RESET: begin
                w_gnt = 1'b0;
            end
            default: begin
                w_gnt       = 1'b0;
                w_core_pass = 1'b0;
            end
        endcase
    end

    // Master port mux: debug when granted, core when allowed, otherwise idle.
    always_comb begin
        if (w_gnt) begin
            o_m_req   = 1'b1;
            o_m_we    = i_dbg_we;
            o_m_addr  = i_dbg_addr;
            o_m_wdata = i_dbg_wdata;
        end else if (w_core_pass) begin
            o_m_req   = i_core_req;
            o_m_we    = i_core_we;
            o_m_addr  = i_core_addr;
            o_m_wdata = i_core_wdata;
        end else begin
            o_m_req   = 1'b0;
            o_m_we    = 1'b0;
            o_m_addr  = {ADDR_W{1'b0}};
            o_m_wdata = {DATA_W{1'b0}};
        end
    end

    assign o_starve_hold = (i_state == ST_RUN) & w_pending & w_starved;

    // Ack pulse and captured read data; a reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= {DATA_W{1'b0}};
        end else if (w_gnt) begin
            r_ack   <= 1'b1;
            r_rdata <= i_m_rdata;
        end else begin
            r_ack   <= 1'b0;
            r_rdata <= r_rdata;
        end
    end

    // Starve counter: counts RUN cycles a pending access is refused; cleared on grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 8'd0;
        end else if (w_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if ((i_state == ST_RUN) && w_pending) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    assign o_dbg_ack   = r_ack;
    assign o_dbg_rdata = r_rdata;

endmodule

// File: rtl/dbg_ctrl.sv
// Debug run-control and memory port sharing between the debug module and the core.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   dbg_halt_req_i/dbg_reset_req_i  halt / reset request levels from the debug module
//   dbg_op_req_i, dbg_mem_*         debug memory access and its completion
//   core_req_i, core_*              core bus master; core_rdata_o mirrors bus data
//   core_idle_i                     core pipeline drained
//   m_*                             shared master port to the bus
//   core_hold_o, core_rst_o         core stall and active-high reset pulse
//   halted_o                        core is halted
module dbg_ctrl
    import dbg_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 8,
    parameter int STARVE_MAX   = 16,
    parameter int HALT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_halt_req_i,
    input  logic              dbg_reset_req_i,
    input  logic              dbg_op_req_i,
    input  logic              dbg_mem_we_i,
    input  logic [ADDR_W-1:0] dbg_mem_addr_i,
    input  logic [DATA_W-1:0] dbg_mem_wdata_i,
    output logic [DATA_W-1:0] dbg_mem_rdata_o,
    output logic              dbg_mem_ack_o,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    input  logic              core_idle_i,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    output logic              core_hold_o,
    output logic              core_rst_o,
    output logic              halted_o
);

    state_e      r_state;
    state_e      w_state_nx;
    logic [7:0]  r_rst_cnt;
    logic [7:0]  w_rst_cnt_nx;
    logic [15:0] r_to_cnt;
    logic [15:0] w_to_cnt_nx;
    logic        w_starve_hold;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_rst_cnt <= 8'd0;
            r_to_cnt  <= 16'd0;
        end else begin
            r_state   <= w_state_nx;
            r_rst_cnt <= w_rst_cnt_nx;
            r_to_cnt  <= w_to_cnt_nx;
        end
    end

    // Next-state logic; a reset request wins over everything, including a
    // reset already in progress, so a held request keeps the pulse stretched.
    always_comb begin
        w_state_nx   = r_state;
        w_rst_cnt_nx = r_rst_cnt;
        w_to_cnt_nx  = r_to_cnt;
        if (dbg_reset_req_i) begin
            w_state_nx   = ST_RESET;
            w_rst_cnt_nx = 8'(RST_CYCLES - 1);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (dbg_halt_req_i) begin
                        w_state_nx  = ST_HALT_WAIT;
                        w_to_cnt_nx = 16'd0;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_HALT_WAIT: begin
                    if (!dbg_halt_req_i) begin
                        w_state_nx = ST_RUN;
                    end else if (core_idle_i || (r_to_cnt == 16'(HALT_TIMEOUT - 1))) begin
                        w_state_nx = ST_HALTED;
                    end else begin
                        w_to_cnt_nx = r_to_cnt + 16'd1;
                    end
                end
                ST_HALTED: begin
                    if (!dbg_halt_req_i) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_state_nx = ST_HALTED;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == 8'd0) begin
                        w_state_nx = dbg_halt_req_i ? ST_HALTED : ST_RUN;
                    end else begin
                        w_rst_cnt_nx = r_rst_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_RUN;
                end
            endcase
        end
    end

    dbg_bus_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_state      (r_state),
        .i_dbg_req    (dbg_op_req_i),
        .i_dbg_we     (dbg_mem_we_i),
        .i_dbg_addr   (dbg_mem_addr_i),
        .i_dbg_wdata  (dbg_mem_wdata_i),
        .o_dbg_rdata  (dbg_mem_rdata_o),
        .o_dbg_ack    (dbg_mem_ack_o),
        .i_core_req   (core_req_i),
        .i_core_we    (core_we_i),
        .i_core_addr  (core_addr_i),
        .i_core_wdata (core_wdata_i),
        .i_m_rdata    (m_rdata_i),
        .o_m_req      (m_req_o),
        .o_m_we       (m_we_o),
        .o_m_addr     (m_addr_o),
        .o_m_wdata    (m_wdata_o),
        .o_starve_hold(w_starve_hold)
    );

    // Outputs decode straight from the state register so they change on the
    // edge that changes state (hold drops on the edge entering RUN).
    assign core_hold_o  = (r_state != ST_RUN) | w_starve_hold;
    assign core_rst_o   = (r_state == ST_RESET);
    assign halted_o     = (r_state == ST_HALTED);
    assign core_rdata_o = m_rdata_i;

endmodule

// File: tb/tb_dbg_ctrl.sv
module tb_dbg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        dbg_halt_req_i;
    logic        dbg_reset_req_i;
    logic        dbg_op_req_i;
    logic        dbg_mem_we_i;
    logic [31:0] dbg_mem_addr_i;
    logic [31:0] dbg_mem_wdata_i;
    logic [31:0] dbg_mem_rdata_o;
    logic        dbg_mem_ack_o;
    logic        core_req_i;
    logic        core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [31:0] core_rdata_o;
    logic        core_idle_i;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        core_hold_o;
    logic        core_rst_o;
    logic        halted_o;

    int n_cmp;
    int n_err;
    int n;

    dbg_ctrl #(
        .RST_CYCLES  (8),
        .STARVE_MAX  (16),
        .HALT_TIMEOUT(64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dbg_halt_req_i (dbg_halt_req_i),
        .dbg_reset_req_i(dbg_reset_req_i),
        .dbg_op_req_i   (dbg_op_req_i),
        .dbg_mem_we_i   (dbg_mem_we_i),
        .dbg_mem_addr_i (dbg_mem_addr_i),
        .dbg_mem_wdata_i(dbg_mem_wdata_i),
        .dbg_mem_rdata_o(dbg_mem_rdata_o),
        .dbg_mem_ack_o  (dbg_mem_ack_o),
        .core_req_i     (core_req_i),
        .core_we_i      (core_we_i),
        .core_addr_i    (core_addr_i),
        .core_wdata_i   (core_wdata_i),
        .core_rdata_o   (core_rdata_o),
        .core_idle_i    (core_idle_i),
        .m_req_o        (m_req_o),
        .m_we_o         (m_we_o),
        .m_addr_o       (m_addr_o),
        .m_wdata_o      (m_wdata_o),
        .m_rdata_i      (m_rdata_i),
        .core_hold_o    (core_hold_o),
        .core_rst_o     (core_rst_o),
        .halted_o       (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        dbg_halt_req_i  = 1'b0;
        dbg_reset_req_i = 1'b0;
        dbg_op_req_i    = 1'b0;
        dbg_mem_we_i    = 1'b0;
        dbg_mem_addr_i  = 32'd0;
        dbg_mem_wdata_i = 32'd0;
        core_req_i      = 1'b0;
        core_we_i       = 1'b0;
        core_addr_i     = 32'd0;
        core_wdata_i    = 32'd0;
        core_idle_i     = 1'b0;
        m_rdata_i       = 32'd0;

        // Reset state
        cyc(); cyc(); #1;
        check_eq("rst_hold",   32'(core_hold_o),   32'd0);
        check_eq("rst_crst",   32'(core_rst_o),    32'd0);
        check_eq("rst_halted", 32'(halted_o),      32'd0);
        check_eq("rst_ack",    32'(dbg_mem_ack_o), 32'd0);
        check_eq("rst_rdata",  dbg_mem_rdata_o,    32'd0);
        check_eq("rst_mreq",   32'(m_req_o),       32'd0);
        // Debug request held during reset must never be acked
        dbg_op_req_i   = 1'b1;
        dbg_mem_addr_i = 32'h0000_0040;
        m_rdata_i      = 32'h5555_AAAA;
        cyc();
        check_eq("rst_op_ack0", 32'(dbg_mem_ack_o), 32'd0);
        cyc();
        check_eq("rst_op_ack1", 32'(dbg_mem_ack_o), 32'd0);
        dbg_op_req_i = 1'b0;
        rst_n        = 1'b1;
        cyc();
        check_eq("rst_op_ack2", 32'(dbg_mem_ack_o), 32'd0);
        check_eq("rst_op_rdata", dbg_mem_rdata_o, 32'd0);

        // Halt with drain
        dbg_halt_req_i = 1'b1;
        core_idle_i    = 1'b0;
        cyc();
        check_eq("hw_hold", 32'(core_hold_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("hw_not_halted", 32'(halted_o), 32'd0);
        end
        core_idle_i = 1'b1;
        #1;
        check_eq("hw_idle_same_cycle", 32'(halted_o), 32'd0);
        cyc();
        check_eq("hw_halted", 32'(halted_o), 32'd1);

        // HALTED read
        dbg_op_req_i   = 1'b1;
        dbg_mem_we_i   = 1'b0;
        dbg_mem_addr_i = 32'h1000_0004;
        m_rdata_i      = 32'hDEAD_BEEF;
        #1;
        check_eq("hr_mreq",  32'(m_req_o), 32'd1);
        check_eq("hr_mwe",   32'(m_we_o),  32'd0);
        check_eq("hr_maddr", m_addr_o,     32'h1000_0004);
        check_eq("hr_ack_early", 32'(dbg_mem_ack_o), 32'd0);
        check_eq("hr_core_rdata", core_rdata_o, 32'hDEAD_BEEF);
        cyc();
        m_rdata_i = 32'h0BAD_0BAD;
        #1;
        check_eq("hr_ack",   32'(dbg_mem_ack_o), 32'd1);
        check_eq("hr_rdata", dbg_mem_rdata_o,    32'hDEAD_BEEF);
        check_eq("hr_mreq_masked", 32'(m_req_o), 32'd0);
        dbg_op_req_i = 1'b0;
        cyc();
        check_eq("hr_ack_pulse", 32'(dbg_mem_ack_o), 32'd0);

        // Release halt
        dbg_halt_req_i = 1'b0;
        core_idle_i    = 1'b0;
        #1;
        check_eq("rel_hold_before", 32'(core_hold_o), 32'd1);
        cyc();
        check_eq("rel_hold", 32'(core_hold_o), 32'd0);
        check_eq("rel_halted", 32'(halted_o), 32'd0);

        // Halt timeout: count cycles from entering HALT_WAIT to halted
        dbg_halt_req_i = 1'b1;
        cyc();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n = n + 1;
            if (halted_o) break;
        end
        check_eq("to_cycles", 32'(n), 32'd64);
        check_eq("to_halted", 32'(halted_o), 32'd1);
        dbg_halt_req_i = 1'b0;
        cyc();
        check_eq("to_release", 32'(halted_o), 32'd0);

        // Reset pulse with halt pending
        dbg_halt_req_i  = 1'b1;
        dbg_reset_req_i = 1'b1;
        cyc();
        dbg_reset_req_i = 1'b0;
        check_eq("rp_rst", 32'(core_rst_o), 32'd1);
        check_eq("rp_hold", 32'(core_hold_o), 32'd1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!core_rst_o) break;
            n = n + 1;
        end
        check_eq("rp_width", 32'(n), 32'd8);
        check_eq("rp_halted", 32'(halted_o), 32'd1);
        dbg_halt_req_i = 1'b0;
        cyc();
        check_eq("rp_run", 32'(core_hold_o), 32'd0);

        // RUN starvation: core hogs the bus, debug write pending
        core_req_i      = 1'b1;
        core_we_i       = 1'b0;
        core_addr_i     = 32'h0000_00A0;
        core_wdata_i    = 32'h0000_0011;
        dbg_op_req_i    = 1'b1;
        dbg_mem_we_i    = 1'b1;
        dbg_mem_addr_i  = 32'h2000_0008;
        dbg_mem_wdata_i = 32'hCAFE_F00D;
        #1;
        check_eq("sv_core_pass", m_addr_o, 32'h0000_00A0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (core_hold_o) break;
            n = n + 1;
            cyc();
        end
        check_eq("sv_wait", 32'(n), 32'd16);
        check_eq("sv_mreq",   32'(m_req_o), 32'd1);
        check_eq("sv_mwe",    32'(m_we_o),  32'd1);
        check_eq("sv_maddr",  m_addr_o,     32'h2000_0008);
        check_eq("sv_mwdata", m_wdata_o,    32'hCAFE_F00D);
        cyc();
        check_eq("sv_ack",    32'(dbg_mem_ack_o), 32'd1);
        check_eq("sv_resume_hold", 32'(core_hold_o), 32'd0);
        check_eq("sv_resume_addr", m_addr_o, 32'h0000_00A0);
        dbg_op_req_i = 1'b0;
        cyc();
        check_eq("sv_ack_pulse", 32'(dbg_mem_ack_o), 32'd0);

        // RUN uncontended read: granted immediately, ack next cycle
        core_req_i     = 1'b0;
        dbg_op_req_i   = 1'b1;
        dbg_mem_we_i   = 1'b0;
        dbg_mem_addr_i = 32'h3000_0010;
        m_rdata_i      = 32'h1234_5678;
        #1;
        check_eq("ur_mreq",  32'(m_req_o), 32'd1);
        check_eq("ur_maddr", m_addr_o,     32'h3000_0010);
        check_eq("ur_hold",  32'(core_hold_o), 32'd0);
        cyc();
        check_eq("ur_ack",   32'(dbg_mem_ack_o), 32'd1);
        check_eq("ur_rdata", dbg_mem_rdata_o,    32'h1234_5678);
        dbg_op_req_i = 1'b0;
        cyc();
        check_eq("ur_ack_pulse", 32'(dbg_mem_ack_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
